// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory-controller port between fetch (p0), CPU data (p1) and DMA (p2).
// Round-robin grant, one transaction in flight. Write strobe held WR_HOLD cycles, then wait for busy low.
// Unaligned requests are acked with err and never reach memory. Waiting requesters hold req until ack.
module mem_bus_arbiter #(
   parameter int READ_WAIT = 2,
   parameter int WR_HOLD   = 2,
   parameter int TIMEOUT   = 64
) (
   input  logic        clk50M,
   input  logic        rst,
   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   output logic        p0_ack,
   output logic [31:0] p0_rdata,
   output logic        p0_err,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p1_ack,
   output logic [31:0] p1_rdata,
   output logic        p1_err,
   input  logic        p2_req,
   input  logic        p2_we,
   input  logic [31:0] p2_addr,
   input  logic [31:0] p2_wdata,
   output logic        p2_ack,
   output logic [31:0] p2_rdata,
   output logic        p2_err,
   output logic        mem_is_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_busy,
   output logic [1:0]  grant_id
);

   localparam int RW_MAX  = (READ_WAIT > WR_HOLD) ? READ_WAIT : WR_HOLD;
   localparam int CNT_MAX = (RW_MAX > TIMEOUT) ? RW_MAX : TIMEOUT;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_WAIT,
      S_WR_ISSUE,
      S_WR_WAIT,
      S_DONE
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_last;
   logic [1:0]    r_grant_id;
   logic          r_mem_is_write;
   logic [31:0]   r_mem_addr;
   logic [31:0]   r_mem_wdata;
   logic [2:0]    r_ack;
   logic [2:0]    r_err;
   logic [31:0]   r_p0_rdata;
   logic [31:0]   r_p1_rdata;
   logic [31:0]   r_p2_rdata;

   logic [2:0]    w_req;
   logic [1:0]    w_c0;
   logic [1:0]    w_c1;
   logic [1:0]    w_c2;
   logic          w_gnt_vld;
   logic [1:0]    w_gnt_idx;
   logic          w_gnt_we;
   logic [31:0]   w_gnt_addr;
   logic [31:0]   w_gnt_wdata;
   logic [2:0]    w_gnt_1h;
   logic [2:0]    w_own_1h;

   assign w_req    = {p2_req, p1_req, p0_req};
   // r_grant_id is 3 only in IDLE, where this one-hot is unused (shifts out to zero)
   assign w_own_1h = 3'b001 << r_grant_id;
   assign w_gnt_1h = 3'b001 << w_gnt_idx;

   // Round-robin pick: search the ports in order starting just after the last granted one
   always_comb begin
      w_c0 = 2'd0;
      w_c1 = 2'd1;
      w_c2 = 2'd2;
      case (r_last)
         2'd0: begin w_c0 = 2'd1; w_c1 = 2'd2; w_c2 = 2'd0; end
         2'd1: begin w_c0 = 2'd2; w_c1 = 2'd0; w_c2 = 2'd1; end
         default: begin w_c0 = 2'd0; w_c1 = 2'd1; w_c2 = 2'd2; end
      endcase
      w_gnt_vld = 1'b1;
      w_gnt_idx = w_c0;
      if (w_req[w_c0])      w_gnt_idx = w_c0;
      else if (w_req[w_c1]) w_gnt_idx = w_c1;
      else if (w_req[w_c2]) w_gnt_idx = w_c2;
      else                  w_gnt_vld = 1'b0;
   end

   // Select the winning port's request fields
   always_comb begin
      w_gnt_we    = p2_we;
      w_gnt_addr  = p2_addr;
      w_gnt_wdata = p2_wdata;
      case (w_gnt_idx)
         2'd0: begin w_gnt_we = p0_we; w_gnt_addr = p0_addr; w_gnt_wdata = p0_wdata; end
         2'd1: begin w_gnt_we = p1_we; w_gnt_addr = p1_addr; w_gnt_wdata = p1_wdata; end
         default: begin w_gnt_we = p2_we; w_gnt_addr = p2_addr; w_gnt_wdata = p2_wdata; end
      endcase
   end

   // Transaction sequencer; every output to memory and requesters is registered here
   always_ff @(posedge clk50M or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_cnt          <= '0;
         r_last         <= 2'd2;
         r_grant_id     <= 2'd3;
         r_mem_is_write <= 1'b0;
         r_mem_addr     <= '0;
         r_mem_wdata    <= '0;
         r_ack          <= '0;
         r_err          <= '0;
         r_p0_rdata     <= '0;
         r_p1_rdata     <= '0;
         r_p2_rdata     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_gnt_vld) begin
                  r_grant_id <= w_gnt_idx;
                  r_cnt      <= '0;
                  if (w_gnt_addr[1:0] != 2'b00) begin
                     // Unaligned: answer with err, leave the memory bus untouched
                     r_ack   <= w_gnt_1h;
                     r_err   <= w_gnt_1h;
                     r_state <= S_DONE;
                  end else begin
                     r_mem_addr  <= w_gnt_addr;
                     r_mem_wdata <= w_gnt_wdata;
                     if (w_gnt_we) begin
                        r_mem_is_write <= 1'b1;
                        r_state        <= S_WR_ISSUE;
                     end else begin
                        r_state <= S_RD_WAIT;
                     end
                  end
               end
            end
            S_RD_WAIT: begin
               // Busy memory freezes the settle count
               if (!mem_busy) begin
                  if (r_cnt == CW'(READ_WAIT - 1)) begin
                     if (r_grant_id == 2'd0) r_p0_rdata <= mem_rdata;
                     if (r_grant_id == 2'd1) r_p1_rdata <= mem_rdata;
                     if (r_grant_id == 2'd2) r_p2_rdata <= mem_rdata;
                     r_ack   <= w_own_1h;
                     r_err   <= '0;
                     r_state <= S_DONE;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            S_WR_ISSUE: begin
               if (r_cnt == CW'(WR_HOLD - 1)) begin
                  r_mem_is_write <= 1'b0;
                  r_cnt          <= '0;
                  r_state        <= S_WR_WAIT;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WR_WAIT: begin
               if (!mem_busy) begin
                  r_ack   <= w_own_1h;
                  r_err   <= '0;
                  r_state <= S_DONE;
               end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                  r_ack   <= w_own_1h;
                  r_err   <= w_own_1h;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               r_ack      <= '0;
               r_err      <= '0;
               r_last     <= r_grant_id;
               r_grant_id <= 2'd3;
               r_state    <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign mem_is_write = r_mem_is_write;
   assign mem_addr     = r_mem_addr;
   assign mem_wdata    = r_mem_wdata;
   assign grant_id     = r_grant_id;
   assign p0_ack       = r_ack[0];
   assign p1_ack       = r_ack[1];
   assign p2_ack       = r_ack[2];
   assign p0_err       = r_err[0];
   assign p1_err       = r_err[1];
   assign p2_err       = r_err[2];
   assign p0_rdata     = r_p0_rdata;
   assign p1_rdata     = r_p1_rdata;
   assign p2_rdata     = r_p2_rdata;

endmodule
